// File: rtl/ethernet_frame_transmitter.sv
// Ethernet II frame builder: buffers one payload, then streams preamble..FCS and gap.
// Optional 802.1Q tag insertion when ETHERNET_TX_VLAN_EN is defined.
module ethernet_frame_transmitter #(
  parameter int BUFFER_DEPTH    = 2048,
  parameter int MAX_PAYLOAD     = 1500,
  parameter int MIN_PAYLOAD     = 46,
  parameter int PREAMBLE_BYTES  = 7,
  parameter int INTER_FRAME_GAP = 12
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        enable,
  input  logic [47:0] mac_destination,
  input  logic [47:0] mac_source,
  input  logic [15:0] ether_type,
`ifdef ETHERNET_TX_VLAN_EN
  input  logic [15:0] vlan_tag,
`endif
  input  logic [7:0]  payload_data,
  input  logic        payload_data_enable,
  input  logic        payload_last,
  output logic        payload_ready,
  output logic [7:0]  transmit_data,
  output logic        transmit_data_valid,
  output logic        busy,
  output logic        truncated,
  output logic [15:0] frame_count
);

  localparam int PTR_W = $clog2(BUFFER_DEPTH);
  localparam int LEN_W = PTR_W + 1;
`ifdef ETHERNET_TX_VLAN_EN
  localparam int HDR_BYTES = 18;
  localparam int MIN_LEN   = MIN_PAYLOAD - 4;
`else
  localparam int HDR_BYTES = 14;
  localparam int MIN_LEN   = MIN_PAYLOAD;
`endif
  localparam int HDR_W = 8 * HDR_BYTES;

  localparam logic [LEN_W-1:0] ONE   = LEN_W'(1);
  localparam logic [LEN_W-1:0] MAX_L = LEN_W'(MAX_PAYLOAD);
  localparam logic [LEN_W-1:0] MIN_L = LEN_W'(MIN_LEN);
  localparam logic [LEN_W-1:0] PRE_L = LEN_W'(PREAMBLE_BYTES - 1);
  localparam logic [LEN_W-1:0] HDR_L = LEN_W'(HDR_BYTES - 1);
  localparam logic [LEN_W-1:0] FCS_L = LEN_W'(3);
  localparam logic [LEN_W-1:0] IFG_L = LEN_W'(INTER_FRAME_GAP - 1);

  typedef enum logic [2:0] {
    LOAD, PREAMBLE, SFD, HEADER, PAYLOAD, PAD, FCS, GAP
  } state_t;

  state_t             state, state_next;
  logic [LEN_W-1:0]   cnt;
  logic [LEN_W-1:0]   wr_ptr, ptr_next;
  logic [LEN_W-1:0]   len;
  logic [HDR_W-1:0]   hdr_q, hdr_in;
  logic [31:0]        crc, fcs_shift;
  logic [7:0]         rd_data;
  logic [PTR_W-1:0]   rd_addr;
  logic               ready_q;
  logic               accept, at_max, commit, crc_en;
  logic [7:0]         buffer [BUFFER_DEPTH];

  function automatic logic [31:0] crc32_byte(input logic [31:0] c,
                                             input logic [7:0]  d);
    logic [31:0] r;
    r = c ^ {24'd0, d};
    for (int i = 0; i < 8; i++)
      r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
    return r;
  endfunction

`ifdef ETHERNET_TX_VLAN_EN
  assign hdr_in = {mac_destination, mac_source, 16'h8100, vlan_tag, ether_type};
`else
  assign hdr_in = {mac_destination, mac_source, ether_type};
`endif

  assign accept    = payload_data_enable && ready_q && (state == LOAD);
  assign at_max    = (wr_ptr == MAX_L - ONE);
  assign commit    = accept && (payload_last || at_max);
  assign truncated = accept && at_max && !payload_last;
  assign crc_en    = state inside {HEADER, PAYLOAD, PAD};
  assign busy      = (state != LOAD);
  assign payload_ready = ready_q;
  // prefetch so the registered read lines up with the PAYLOAD counter
  assign rd_addr   = (state == PAYLOAD) ? PTR_W'(cnt + ONE) : '0;
  assign fcs_shift = (~crc) >> {cnt[1:0], 3'b000};

  always_comb begin
    state_next = state;
    unique case (state)
      LOAD:     if (commit) state_next = PREAMBLE;
      PREAMBLE: if (cnt == PRE_L) state_next = SFD;
      SFD:      state_next = HEADER;
      HEADER:   if (cnt == HDR_L) state_next = PAYLOAD;
      PAYLOAD:  if (cnt == len - ONE)
                  state_next = (len < MIN_L) ? PAD : FCS;
      PAD:      if (cnt + len == MIN_L - ONE) state_next = FCS;
      FCS:      if (cnt == FCS_L) state_next = GAP;
      GAP:      if (cnt == IFG_L) state_next = LOAD;
      default:  state_next = LOAD;
    endcase
  end

  always_comb begin
    ptr_next = accept ? wr_ptr + ONE : wr_ptr;
    if (state != LOAD && state_next == LOAD) ptr_next = '0;
  end

  always_comb begin
    transmit_data       = 8'h00;
    transmit_data_valid = 1'b0;
    unique case (state)
      PREAMBLE: begin transmit_data = 8'h55; transmit_data_valid = 1'b1; end
      SFD:      begin transmit_data = 8'hD5; transmit_data_valid = 1'b1; end
      HEADER:   begin
        transmit_data = hdr_q[HDR_W-1 -: 8];
        transmit_data_valid = 1'b1;
      end
      PAYLOAD:  begin transmit_data = rd_data; transmit_data_valid = 1'b1; end
      PAD:      transmit_data_valid = 1'b1;
      FCS:      begin
        transmit_data = fcs_shift[7:0];
        transmit_data_valid = 1'b1;
      end
      default:  ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (accept) buffer[wr_ptr[PTR_W-1:0]] <= payload_data;
    rd_data <= buffer[rd_addr];
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= LOAD;
      cnt         <= '0;
      wr_ptr      <= '0;
      ready_q     <= 1'b0;
      len         <= '0;
      hdr_q       <= '0;
      crc         <= '1;
      frame_count <= '0;
    end else begin
      state   <= state_next;
      cnt     <= (state_next != state) ? '0 : cnt + ONE;
      wr_ptr  <= ptr_next;
      ready_q <= (state_next == LOAD) && enable && (ptr_next < MAX_L);
      if (commit) begin
        len   <= wr_ptr + ONE;
        hdr_q <= hdr_in;
      end else if (state == HEADER) begin
        hdr_q <= hdr_q << 8;
      end
      if (state == LOAD) crc <= '1;
      else if (crc_en)   crc <= crc32_byte(crc, transmit_data);
      if (state == FCS && cnt == FCS_L) frame_count <= frame_count + 16'd1;
    end
  end

endmodule
